// File: rtl/rf_wb_ctrl.sv
// Write-port controller for the 32x32 register file: merges unstallable ALU results
// with FIFO-buffered load returns and tracks loads outstanding per register.
module rf_wb_ctrl #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 5,
  parameter  int DW    = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ALU_WE,
  input  logic [AW-1:0] ALU_WA,
  input  logic [DW-1:0] ALU_WD,
  input  logic          LD_ISSUE,
  input  logic [AW-1:0] LD_RD,
  input  logic          LD_VALID,
  output logic          LD_READY,
  input  logic [AW-1:0] LD_WA,
  input  logic [DW-1:0] LD_WD,
  output logic          WE,
  output logic [AW-1:0] WA,
  output logic [DW-1:0] WD3,
  output logic [31:0]   PENDING,
  output logic [CW-1:0] FIFO_COUNT
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [AW-1:0] mem_wa_r [DEPTH];
  logic [DW-1:0] mem_wd_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          we_r;
  logic [AW-1:0] wa_r;
  logic [DW-1:0] wd_r;
  logic [31:0]   pend_r;

  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] head_wa_s;
  logic [DW-1:0] head_wd_s;
  logic [31:0]   set_mask_s;
  logic [31:0]   clr_mask_s;
  logic [31:0]   pend_nxt_s;
  logic [CW-1:0] count_nxt_s;

  assign LD_READY   = (count_r != FULL_CNT);
  assign WE         = we_r;
  assign WA         = wa_r;
  assign WD3        = wd_r;
  assign PENDING    = pend_r;
  assign FIFO_COUNT = count_r;

  assign push_s    = LD_VALID & LD_READY;
  assign head_wa_s = mem_wa_r[rd_ptr_r];
  assign head_wd_s = mem_wd_r[rd_ptr_r];

  // Handshake, drain arbitration (ALU always wins) and scoreboard next state
  always_comb begin
    pop_s       = 1'b0;
    set_mask_s  = 32'd0;
    clr_mask_s  = 32'd0;
    count_nxt_s = count_r;
    if (!ALU_WE && (count_r != {CW{1'b0}})) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (LD_ISSUE && (LD_RD != {AW{1'b0}})) begin
      set_mask_s = 32'd1 << LD_RD;
    end else begin
      set_mask_s = 32'd0;
    end
    if (pop_s) begin
      clr_mask_s = 32'd1 << head_wa_s;
    end else begin
      clr_mask_s = 32'd0;
    end
    // set applied after clear so a same-cycle issue to the retiring register wins
    pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_wa_r[i] <= {AW{1'b0}};
        mem_wd_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_wa_r[wr_ptr_r] <= LD_WA;
        mem_wd_r[wr_ptr_r] <= LD_WD;
        wr_ptr_r           <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered write port; x0 targets are consumed without asserting WE
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_r <= 1'b0;
      wa_r <= {AW{1'b0}};
      wd_r <= {DW{1'b0}};
    end else if (ALU_WE) begin
      we_r <= (ALU_WA != {AW{1'b0}});
      wa_r <= ALU_WA;
      wd_r <= ALU_WD;
    end else if (pop_s) begin
      we_r <= (head_wa_s != {AW{1'b0}});
      wa_r <= head_wa_s;
      wd_r <= head_wd_s;
    end else begin
      we_r <= 1'b0;
    end
  end

  // Pending-load scoreboard
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_r <= 32'd0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed, table-driven bench for rf_wb_ctrl with hand-written multi-cycle sequences.
module tb_rf_wb_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        ALU_WE;
  logic [4:0]  ALU_WA;
  logic [31:0] ALU_WD;
  logic        LD_ISSUE;
  logic [4:0]  LD_RD;
  logic        LD_VALID;
  logic        LD_READY;
  logic [4:0]  LD_WA;
  logic [31:0] LD_WD;
  logic        WE;
  logic [4:0]  WA;
  logic [31:0] WD3;
  logic [31:0] PENDING;
  logic [2:0]  FIFO_COUNT;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_WE(ALU_WE), .ALU_WA(ALU_WA), .ALU_WD(ALU_WD),
    .LD_ISSUE(LD_ISSUE), .LD_RD(LD_RD),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_WA(LD_WA), .LD_WD(LD_WD),
    .WE(WE), .WA(WA), .WD3(WD3), .PENDING(PENDING), .FIFO_COUNT(FIFO_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_valid;
    logic [4:0]  ld_wa;
    logic [31:0] ld_wd;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
    logic [2:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_we(input string name, input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd);
    chk({name, ".WE"}, {31'd0, WE}, {31'd0, e_we});
    if (e_we) begin
      chk({name, ".WA"}, {27'd0, WA}, {27'd0, e_wa});
      chk({name, ".WD3"}, WD3, e_wd);
    end
  endtask

  task automatic chk_q(input string name, input logic [2:0] e_cnt, input logic e_rdy);
    chk({name, ".COUNT"}, {29'd0, FIFO_COUNT}, {29'd0, e_cnt});
    chk({name, ".READY"}, {31'd0, LD_READY}, {31'd0, e_rdy});
  endtask

  task automatic drive(input logic a_we, input logic [4:0] a_wa, input logic [31:0] a_wd,
                       input logic iss, input logic [4:0] rd,
                       input logic v, input logic [4:0] l_wa, input logic [31:0] l_wd);
    ALU_WE = a_we; ALU_WA = a_wa; ALU_WD = a_wd;
    LD_ISSUE = iss; LD_RD = rd;
    LD_VALID = v; LD_WA = l_wa; LD_WD = l_wd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // cycle-by-cycle vectors starting from reset state
    tbl[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b1, 5'd7,  32'hDEADBEEF, 32'd0,       3'd0, 1'b1};
    tbl[1]  = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b0, 5'd0,  32'h11111111, 32'd0,       3'd0, 1'b1};
    tbl[2]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b0, 5'd0,  32'h11111111, 32'd0,       3'd0, 1'b1};
    tbl[3]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd3, 1'b0, 5'd0,  32'd0,
                1'b0, 5'd0,  32'h11111111, 32'h8,       3'd0, 1'b1};
    tbl[4]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 1'b1, 5'd3,  32'h12345678,
                1'b0, 5'd0,  32'h11111111, 32'h8,       3'd1, 1'b1};
    tbl[5]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b1, 5'd3,  32'h12345678, 32'd0,       3'd0, 1'b1};
    tbl[6]  = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b0, 5'd3,  32'h12345678, 32'd0,       3'd0, 1'b1};
    tbl[7]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 1'b1, 5'd0,  32'hAAAA5555,
                1'b0, 5'd3,  32'h12345678, 32'd0,       3'd1, 1'b1};
    tbl[8]  = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b0, 5'd0,  32'hAAAA5555, 32'd0,       3'd0, 1'b1};
    tbl[9]  = '{1'b1, 5'd10, 32'h00000001, 1'b0, 5'd0, 1'b1, 5'd12, 32'h00000002,
                1'b1, 5'd10, 32'h00000001, 32'd0,       3'd1, 1'b1};
    tbl[10] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b1, 5'd12, 32'h00000002, 32'd0,       3'd0, 1'b1};
    tbl[11] = '{1'b0, 5'd0,  32'd0,        1'b0, 5'd0, 1'b0, 5'd0,  32'd0,
                1'b0, 5'd12, 32'h00000002, 32'd0,       3'd0, 1'b1};

    idle();
    RST_N = 1'b0;
    #12;
    chk("rst.WE", {31'd0, WE}, 32'd0);
    chk("rst.WA", {27'd0, WA}, 32'd0);
    chk("rst.WD3", WD3, 32'd0);
    chk("rst.PENDING", PENDING, 32'd0);
    chk_q("rst", 3'd0, 1'b1);
    RST_N = 1'b1;
    tick();

    // table: every output compared after each edge, including held WA/WD3
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].alu_we, tbl[i].alu_wa, tbl[i].alu_wd, tbl[i].ld_issue, tbl[i].ld_rd,
            tbl[i].ld_valid, tbl[i].ld_wa, tbl[i].ld_wd);
      tick();
      chk($sformatf("vec%0d.WE", i), {31'd0, WE}, {31'd0, tbl[i].e_we});
      chk($sformatf("vec%0d.WA", i), {27'd0, WA}, {27'd0, tbl[i].e_wa});
      chk($sformatf("vec%0d.WD3", i), WD3, tbl[i].e_wd);
      chk($sformatf("vec%0d.PENDING", i), PENDING, tbl[i].e_pend);
      chk($sformatf("vec%0d.COUNT", i), {29'd0, FIFO_COUNT}, {29'd0, tbl[i].e_cnt});
      chk($sformatf("vec%0d.READY", i), {31'd0, LD_READY}, {31'd0, tbl[i].e_rdy});
    end

    // priority and fill: ALU holds the port for 6 cycles while loads r1..r5 arrive
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, 5'(20 + c), 32'(c), 1'b0, 5'd0, 1'b1, 5'(1 + c), 32'(256 + 1 + c));
      else       drive(1'b1, 5'(20 + c), 32'(c), 1'b0, 5'd0, 1'b1, 5'd5, 32'h105);
      tick();
      chk_we($sformatf("fill%0d", c), 1'b1, 5'(20 + c), 32'(c));
      chk_q($sformatf("fill%0d", c), (c < 4) ? 3'(c + 1) : 3'd4, (c < 3));
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h105);
    tick();
    chk_we("drain1", 1'b1, 5'd1, 32'h101);
    chk_q("drain1", 3'd3, 1'b1);
    tick();
    chk_we("drain2", 1'b1, 5'd2, 32'h102);
    chk_q("drain2", 3'd3, 1'b1);
    idle();
    for (int r = 3; r <= 5; r++) begin
      tick();
      chk_we($sformatf("drain%0d", r), 1'b1, 5'(r), 32'(256 + r));
      chk_q($sformatf("drain%0d", r), 3'(5 - r), 1'b1);
    end
    tick();
    chk_we("drained", 1'b0, 5'd0, 32'd0);

    // simultaneous push and pop at count 2
    drive(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h606);
    tick();
    drive(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h707);
    tick();
    chk_we("pp.pre", 1'b0, 5'd0, 32'd0);
    chk_q("pp.pre", 3'd2, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h808);
    tick();
    chk_we("pp.both", 1'b1, 5'd6, 32'h606);
    chk_q("pp.both", 3'd2, 1'b1);
    idle();
    tick();
    chk_we("pp.r7", 1'b1, 5'd7, 32'h707);
    tick();
    chk_we("pp.r8", 1'b1, 5'd8, 32'h808);
    chk_q("pp.end", 3'd0, 1'b1);

    // scoreboard race: set and clear of r9 in the same cycle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    tick();
    chk("race.set", PENDING, 32'h200);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h909);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    tick();
    chk_we("race.pop", 1'b1, 5'd9, 32'h909);
    chk("race.PENDING", PENDING, 32'h200);
    idle();

    // reset mid-operation with three loads queued
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd1, 32'hCAFE0000, 1'b0, 5'd0, 1'b1, 5'(5 + k), 32'h50);
      tick();
    end
    chk_q("pre_rst", 3'd3, 1'b1);
    chk("pre_rst.PENDING", PENDING, 32'h220);
    chk_we("pre_rst", 1'b1, 5'd1, 32'hCAFE0000);
    idle();
    #2;
    RST_N = 1'b0;
    #1;
    chk("mrst.WE", {31'd0, WE}, 32'd0);
    chk("mrst.PENDING", PENDING, 32'd0);
    chk_q("mrst", 3'd0, 1'b1);
    #4;
    RST_N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("post_rst%0d.WE", k), {31'd0, WE}, 32'd0);
      chk($sformatf("post_rst%0d.COUNT", k), {29'd0, FIFO_COUNT}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
